// File: rtl/ctrl_pkg.sv
// Shared decode constants, control-vector type and shadow FSM state for ctrl_decode_pipe.
package ctrl_pkg;

   localparam logic [1:0] CLS_LDA = 2'b00;
   localparam logic [1:0] CLS_STA = 2'b01;
   localparam logic [1:0] CLS_IMM = 2'b10;
   localparam logic [1:0] CLS_BAF = 2'b11;

   localparam int SHADOW_CNT_W = 4;

   // {branch, flush, regwrite, memwrite, memtoreg, immediate}
   typedef logic [5:0] ctrl_vec_t;

   localparam ctrl_vec_t VEC_LDA = 6'b001011;
   localparam ctrl_vec_t VEC_STA = 6'b000100;
   localparam ctrl_vec_t VEC_IMM = 6'b001001;
   localparam ctrl_vec_t VEC_BAF = 6'b110000;

   typedef enum logic {ST_RUN, ST_SHADOW} state_t;

   function automatic ctrl_vec_t decode_class(input logic [1:0] cls);
      ctrl_vec_t v;
      unique case (cls)
         CLS_LDA: v = VEC_LDA;
         CLS_STA: v = VEC_STA;
         CLS_IMM: v = VEC_IMM;
         CLS_BAF: v = VEC_BAF;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// Fetch-to-execute decode bus; slave side is the decode stage.
// Statistics outputs exist only when CTRL_STATS_EN is defined.
interface ctrl_decode_pipe_if #(
   parameter int OPCODE_W  = 4,
   parameter int ALUFUNC_W = 2,
   parameter int STAT_W    = 16
);
   logic                 i_valid;
   logic [OPCODE_W-1:0]  i_opcode;
   logic                 i_stall;
   logic                 i_flush_ext;
   logic                 o_ready;
   logic                 o_valid;
   logic                 o_branch;
   logic                 o_flush;
   logic                 o_regwrite;
   logic                 o_memwrite;
   logic                 o_memtoreg;
   logic                 o_immediate;
   logic [ALUFUNC_W-1:0] o_alufunc;
`ifdef CTRL_STATS_EN
   logic [STAT_W-1:0]    o_stat_issued;
   logic [STAT_W-1:0]    o_stat_branch;
   logic [STAT_W-1:0]    o_stat_squash;
`endif

   modport slave (
      input  i_valid, i_opcode, i_stall, i_flush_ext,
      output o_ready, o_valid, o_branch, o_flush, o_regwrite,
             o_memwrite, o_memtoreg, o_immediate, o_alufunc
`ifdef CTRL_STATS_EN
      , output o_stat_issued, o_stat_branch, o_stat_squash
`endif
   );

   modport master (
      output i_valid, i_opcode, i_stall, i_flush_ext,
      input  o_ready, o_valid, o_branch, o_flush, o_regwrite,
             o_memwrite, o_memtoreg, o_immediate, o_alufunc
`ifdef CTRL_STATS_EN
      , input o_stat_issued, o_stat_branch, o_stat_squash
`endif
   );

endinterface

// File: rtl/branch_shadow_ctr.sv
// Loadable down-counter tracking remaining branch-shadow slots.
// Priority: clear > load > decrement; otherwise holds.
module branch_shadow_ctr #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_clear,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic [W-1:0] o_count,
   output logic         o_active
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = '0;
      end else if (i_load) begin
         count_d = i_load_val;
      end else if (i_dec && count_q != '0) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_count  = count_q;
   assign o_active = (count_q != '0);

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered opcode decoder with stall/flush handshake and BAF branch-shadow squashing.
// Optional saturating statistics counters are built when CTRL_STATS_EN is defined.
module ctrl_decode_pipe
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W       = 4,
   parameter int ALUFUNC_W      = 2,
   parameter int BRANCH_BUBBLES = 2,
   parameter int STAT_W         = 16
) (
   input logic               i_clk,
   input logic               i_reset,
   ctrl_decode_pipe_if.slave bus
);

   state_t                   state_q, state_d;
   logic                     valid_q, valid_d;
   ctrl_vec_t                ctrl_q, ctrl_d;
   logic [ALUFUNC_W-1:0]     func_q, func_d;

   logic [SHADOW_CNT_W-1:0]  cnt;
   logic                     cnt_active;
   logic                     cnt_clr, cnt_load, cnt_dec;
   logic                     issue_baf, squash;

   logic                     accept;
   logic [1:0]               cls;
   logic [ALUFUNC_W-1:0]     func;

   assign accept = bus.i_valid && !bus.i_stall;
   assign cls    = bus.i_opcode[OPCODE_W-1 -: 2];
   assign func   = bus.i_opcode[ALUFUNC_W-1:0];

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      ctrl_d    = ctrl_q;
      func_d    = func_q;
      cnt_clr   = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      issue_baf = 1'b0;
      squash    = 1'b0;
      if (bus.i_flush_ext) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         func_d  = '0;
         state_d = ST_RUN;
         cnt_clr = 1'b1;
         squash  = accept;
      end else if (!bus.i_stall) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         func_d  = '0;
         unique case (state_q)
            ST_RUN: begin
               if (accept) begin
                  valid_d = 1'b1;
                  ctrl_d  = decode_class(cls);
                  func_d  = func;
                  if (cls == CLS_BAF) begin
                     issue_baf = 1'b1;
                     if (BRANCH_BUBBLES != 0) begin
                        state_d  = ST_SHADOW;
                        cnt_load = 1'b1;
                     end
                  end
               end
            end
            ST_SHADOW: begin
               // Everything in the shadow is a bubble; a BAF here must not reload.
               squash  = accept;
               cnt_dec = cnt_active;
               if (cnt == SHADOW_CNT_W'(1) || !cnt_active) begin
                  state_d = ST_RUN;
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_RUN;
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         func_q  <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         func_q  <= func_d;
      end
   end

   branch_shadow_ctr #(.W(SHADOW_CNT_W)) u_shadow_ctr (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clear    (cnt_clr),
      .i_load     (cnt_load),
      .i_load_val (SHADOW_CNT_W'(BRANCH_BUBBLES)),
      .i_dec      (cnt_dec),
      .o_count    (cnt),
      .o_active   (cnt_active)
   );

   assign bus.o_ready     = !bus.i_stall;
   assign bus.o_valid     = valid_q;
   assign bus.o_branch    = ctrl_q[5];
   assign bus.o_flush     = ctrl_q[4];
   assign bus.o_regwrite  = ctrl_q[3];
   assign bus.o_memwrite  = ctrl_q[2];
   assign bus.o_memtoreg  = ctrl_q[1];
   assign bus.o_immediate = ctrl_q[0];
   assign bus.o_alufunc   = func_q;

`ifdef CTRL_STATS_EN
   logic [STAT_W-1:0] issued_q, branch_q, squash_q;
   logic              inc_issued;

   assign inc_issued = valid_d && !bus.i_stall && !bus.i_flush_ext;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         issued_q <= '0;
         branch_q <= '0;
         squash_q <= '0;
      end else begin
         if (inc_issued && issued_q != '1) issued_q <= issued_q + STAT_W'(1);
         if (issue_baf && branch_q != '1) branch_q <= branch_q + STAT_W'(1);
         if (squash && squash_q != '1)    squash_q <= squash_q + STAT_W'(1);
      end
   end

   assign bus.o_stat_issued = issued_q;
   assign bus.o_stat_branch = branch_q;
   assign bus.o_stat_squash = squash_q;
`endif

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Table-driven bench for ctrl_decode_pipe: one instance with a two-slot branch shadow,
// one with the shadow disabled, driven in lockstep and checked through a scoreboard queue.
module tb_ctrl_decode_pipe;

   // Expected output packing: {valid, branch, flush, regwrite, memwrite, memtoreg, immediate, alufunc}
   localparam logic [8:0] O_BUB  = 9'b0_000000_00;
   localparam logic [8:0] O_LDA  = 9'b1_001011_00;
   localparam logic [8:0] O_STA  = 9'b1_000100_01;
   localparam logic [8:0] O_IMM  = 9'b1_001001_10;
   localparam logic [8:0] O_BAF  = 9'b1_110000_11;
   localparam logic [8:0] O_IMM9 = 9'b1_001001_01;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ctrl_decode_pipe_if #(.OPCODE_W(4), .ALUFUNC_W(2), .STAT_W(16)) bus2 ();
   ctrl_decode_pipe_if #(.OPCODE_W(4), .ALUFUNC_W(2), .STAT_W(16)) bus0 ();

   ctrl_decode_pipe #(.OPCODE_W(4), .ALUFUNC_W(2), .BRANCH_BUBBLES(2), .STAT_W(16)) dut2 (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus2)
   );

   ctrl_decode_pipe #(.OPCODE_W(4), .ALUFUNC_W(2), .BRANCH_BUBBLES(0), .STAT_W(16)) dut0 (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus0)
   );

   typedef struct {
      logic       v;
      logic [3:0] op;
      logic       st;
      logic       fl;
      logic [8:0] e2;
      logic [8:0] e0;
      string      name;
   } vec_t;

   localparam int N = 21;
   vec_t tbl [N];
   logic [17:0] sb [$];
   int checks = 0;
   int failures = 0;

   function automatic logic [8:0] out2();
      return {bus2.o_valid, bus2.o_branch, bus2.o_flush, bus2.o_regwrite, bus2.o_memwrite,
              bus2.o_memtoreg, bus2.o_immediate, bus2.o_alufunc};
   endfunction

   function automatic logic [8:0] out0();
      return {bus0.o_valid, bus0.o_branch, bus0.o_flush, bus0.o_regwrite, bus0.o_memwrite,
              bus0.o_memtoreg, bus0.o_immediate, bus0.o_alufunc};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end else begin
         $display("ok   %s value=%h", name, act);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic st, input logic fl);
      bus2.i_valid = v;  bus2.i_opcode = op;  bus2.i_stall = st;  bus2.i_flush_ext = fl;
      bus0.i_valid = v;  bus0.i_opcode = op;  bus0.i_stall = st;  bus0.i_flush_ext = fl;
   endtask

   task automatic step(input logic v, input logic [3:0] op, input logic st, input logic fl,
                       input logic [8:0] e2, input logic [8:0] e0, input string name);
      logic [17:0] exp;
      @(negedge clk);
      drive(v, op, st, fl);
      sb.push_back({e2, e0});
      #1;
      check({name, "/ready"}, 32'(bus2.o_ready), 32'(!st));
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      check({name, "/bb2"}, 32'(out2()), 32'(exp[17:9]));
      check({name, "/bb0"}, 32'(out0()), 32'(exp[8:0]));
   endtask

   initial begin
      //            v     op    st    fl    bb=2    bb=0
      tbl[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, O_LDA, O_LDA, "sweep_lda"};
      tbl[1]  = '{1'b1, 4'h5, 1'b0, 1'b0, O_STA, O_STA, "sweep_sta"};
      tbl[2]  = '{1'b1, 4'hA, 1'b0, 1'b0, O_IMM, O_IMM, "sweep_imm"};
      tbl[3]  = '{1'b1, 4'hF, 1'b0, 1'b0, O_BAF, O_BAF, "sweep_baf"};
      tbl[4]  = '{1'b1, 4'hA, 1'b0, 1'b0, O_BUB, O_IMM, "shadow1"};
      tbl[5]  = '{1'b1, 4'h0, 1'b0, 1'b0, O_BUB, O_LDA, "shadow2"};
      tbl[6]  = '{1'b1, 4'h0, 1'b0, 1'b0, O_LDA, O_LDA, "after_shadow"};
      tbl[7]  = '{1'b1, 4'hF, 1'b0, 1'b0, O_BAF, O_BAF, "stl_baf"};
      tbl[8]  = '{1'b1, 4'h0, 1'b1, 1'b0, O_BAF, O_BAF, "stl_hold1"};
      tbl[9]  = '{1'b1, 4'h0, 1'b1, 1'b0, O_BAF, O_BAF, "stl_hold2"};
      tbl[10] = '{1'b1, 4'h0, 1'b1, 1'b0, O_BAF, O_BAF, "stl_hold3"};
      tbl[11] = '{1'b1, 4'h0, 1'b0, 1'b0, O_BUB, O_LDA, "stl_shadow1"};
      tbl[12] = '{1'b1, 4'hF, 1'b0, 1'b0, O_BUB, O_BAF, "baf_in_shadow"};
      tbl[13] = '{1'b1, 4'h5, 1'b0, 1'b0, O_STA, O_STA, "no_extend"};
      tbl[14] = '{1'b0, 4'hF, 1'b0, 1'b0, O_BUB, O_BUB, "invalid_bubble"};
      tbl[15] = '{1'b1, 4'hF, 1'b0, 1'b0, O_BAF, O_BAF, "fl_baf"};
      tbl[16] = '{1'b1, 4'h5, 1'b1, 1'b1, O_BUB, O_BUB, "flush_over_stall"};
      tbl[17] = '{1'b1, 4'h5, 1'b0, 1'b0, O_STA, O_STA, "after_flush_run"};
      tbl[18] = '{1'b1, 4'h0, 1'b0, 1'b1, O_BUB, O_BUB, "flush_run"};
      tbl[19] = '{1'b1, 4'hA, 1'b1, 1'b0, O_BUB, O_BUB, "stall_bubble"};
      tbl[20] = '{1'b0, 4'h0, 1'b0, 1'b0, O_BUB, O_BUB, "idle"};

      rst = 1'b1;
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      #1;
      check("reset_bb2", 32'(out2()), 32'(O_BUB));
      check("reset_bb0", 32'(out0()), 32'(O_BUB));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < N; i++) begin
         step(tbl[i].v, tbl[i].op, tbl[i].st, tbl[i].fl, tbl[i].e2, tbl[i].e0, tbl[i].name);
`ifdef CTRL_STATS_EN
         if (i == 6) begin
            check("stat_issued", 32'(bus2.o_stat_issued), 32'd5);
            check("stat_branch", 32'(bus2.o_stat_branch), 32'd1);
            check("stat_squash", 32'(bus2.o_stat_squash), 32'd2);
         end
`endif
      end

      // Reset asserted mid-shadow with one slot left, then a fresh IMM after release.
      step(1'b1, 4'hF, 1'b0, 1'b0, O_BAF, O_BAF, "rst_baf");
      step(1'b1, 4'h0, 1'b0, 1'b0, O_BUB, O_LDA, "rst_shadow1");
      @(negedge clk);
      drive(1'b1, 4'h0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_bb2", 32'(out2()), 32'(O_BUB));
      check("rst_async_bb0", 32'(out0()), 32'(O_BUB));
      @(posedge clk);
      #1;
      check("rst_held_bb2", 32'(out2()), 32'(O_BUB));
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      step(1'b1, 4'h9, 1'b0, 1'b0, O_IMM9, O_IMM9, "post_rst_imm");
      step(1'b0, 4'h0, 1'b0, 1'b0, O_BUB, O_BUB, "post_rst_idle");

      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
